// File: rtl/seq_detect_pkg.sv
// Shared defaults and the prefix/suffix comparison used by the programmable
// Mealy sequence detector.
package seq_detect_pkg;

    localparam int         PAT_W_DEF       = 8;
    localparam int         CNT_W_DEF       = 8;
    localparam int         MAX_PAT_W       = 32;
    localparam logic [7:0] RST_PATTERN_DEF = 8'b0001_1011;
    localparam int         RST_LEN_DEF     = 5;
    localparam logic       RST_OVERLAP_DEF = 1'b1;

    typedef enum logic {
        OVL_RESTART = 1'b0,
        OVL_OVERLAP = 1'b1
    } overlap_mode_e;

    // True when the first k received-order pattern bits equal the last k history
    // bits (hist[0] newest). Shifting the pattern down by len-k lines its head up
    // with hist[k-1:0]; callers guarantee k <= len.
    function automatic logic prefix_match(
        input logic [MAX_PAT_W-1:0] pattern,
        input int                   len,
        input logic [MAX_PAT_W-1:0] hist,
        input int                   k
    );
        logic [MAX_PAT_W-1:0] head_s;
        logic [MAX_PAT_W-1:0] mask_s;
        head_s = pattern >> (len - k);
        mask_s = ~({MAX_PAT_W{1'b1}} << k);
        return (((head_s ^ hist) & mask_s) == {MAX_PAT_W{1'b0}});
    endfunction

endpackage

// File: rtl/seq_next_state.sv
// Combinational next-state search: longest pattern prefix that is a suffix of
// the history including the incoming bit, plus the overlap fallback state.
module seq_next_state
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] state,
    input  logic [PAT_W-1:0] hist,
    input  logic             bit_in,
    output logic [LEN_W-1:0] next_k,
    output logic             match,
    output logic [LEN_W-1:0] fail_k
);

    logic [MAX_PAT_W-1:0] pat_ext_s;
    logic [MAX_PAT_W-1:0] hist_ext_s;
    logic                 hit_s;
    int                   len_s;
    int                   bound_s;

    // Unrolled search over every candidate length; later (longer) hits override.
    always_comb begin
        pat_ext_s  = MAX_PAT_W'(pattern);
        hist_ext_s = MAX_PAT_W'({hist[PAT_W-2:0], bit_in});
        len_s      = int'(len);
        bound_s    = ((int'(state) + 1) < len_s) ? (int'(state) + 1) : len_s;
        hit_s      = 1'b0;
        next_k     = {LEN_W{1'b0}};
        fail_k     = {LEN_W{1'b0}};
        for (int k = 1; k <= PAT_W; k++) begin
            hit_s  = prefix_match(pat_ext_s, len_s, hist_ext_s, k) && (k <= bound_s);
            next_k = hit_s ? LEN_W'(k) : next_k;
            fail_k = (hit_s && (k < len_s)) ? LEN_W'(k) : fail_k;
        end
        match = (int'(next_k) == len_s);
    end

endmodule

// File: rtl/seq_detect_mealy.sv
// Runtime-programmable Mealy sequence detector with saturating match counter;
// reset configuration reproduces the legacy overlapping 11011 detector.
module seq_detect_mealy
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W       = PAT_W_DEF,
    parameter int               LEN_W       = $clog2(PAT_W + 1),
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(RST_PATTERN_DEF),
    parameter int               RST_LEN     = RST_LEN_DEF,
    parameter logic             RST_OVERLAP = RST_OVERLAP_DEF
) (
    input  logic             clk_125M,
    input  logic             clear_n,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             out,
    output logic [LEN_W-1:0] present_state,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    logic [PAT_W-1:0] pattern_r;
    logic [LEN_W-1:0] len_r;
    overlap_mode_e    overlap_r;
    logic [PAT_W-1:0] hist_r;
    logic [LEN_W-1:0] state_r;
    logic [CNT_W-1:0] match_cnt_r;
    logic             cfg_err_r;

    logic [LEN_W-1:0] next_k_s;
    logic [LEN_W-1:0] fail_k_s;
    logic             match_s;
    logic             cfg_legal_s;
    logic             cnt_full_s;

    assign cfg_legal_s = (cfg_len != {LEN_W{1'b0}}) && (int'(cfg_len) <= PAT_W);
    assign cnt_full_s  = (match_cnt_r == {CNT_W{1'b1}});

    seq_next_state #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_next (
        .pattern (pattern_r),
        .len     (len_r),
        .state   (state_r),
        .hist    (hist_r),
        .bit_in  (bit_in),
        .next_k  (next_k_s),
        .match   (match_s),
        .fail_k  (fail_k_s)
    );

    // clear_n gating keeps the flag low while reset is asserted, whatever the inputs.
    assign out = clear_n & bit_valid & match_s & ~cfg_load;

    // Configuration, history, state and counter; a load takes priority over a bit.
    always_ff @(posedge clk_125M or negedge clear_n) begin
        if (!clear_n) begin
            pattern_r   <= RST_PATTERN;
            len_r       <= LEN_W'(RST_LEN);
            overlap_r   <= overlap_mode_e'(RST_OVERLAP);
            hist_r      <= {PAT_W{1'b0}};
            state_r     <= {LEN_W{1'b0}};
            match_cnt_r <= {CNT_W{1'b0}};
            cfg_err_r   <= 1'b0;
        end else if (cfg_load) begin
            if (cfg_legal_s) begin
                pattern_r   <= cfg_pattern;
                len_r       <= cfg_len;
                overlap_r   <= overlap_mode_e'(cfg_overlap);
                hist_r      <= {PAT_W{1'b0}};
                state_r     <= {LEN_W{1'b0}};
                match_cnt_r <= {CNT_W{1'b0}};
                cfg_err_r   <= 1'b0;
            end else begin
                cfg_err_r   <= 1'b1;
            end
        end else if (bit_valid) begin
            hist_r <= {hist_r[PAT_W-2:0], bit_in};
            if (match_s) begin
                state_r <= (overlap_r == OVL_OVERLAP) ? fail_k_s : {LEN_W{1'b0}};
                if (!cnt_full_s) begin
                    match_cnt_r <= match_cnt_r + CNT_W'(1'b1);
                end
            end else begin
                state_r <= next_k_s;
            end
        end
    end

    assign present_state = state_r;
    assign match_cnt     = match_cnt_r;
    assign cfg_err       = cfg_err_r;

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Scoreboard bench for seq_detect_mealy: directed streams with hand-derived
// expectations; a second instance with a 2-bit counter covers saturation.
module tb_seq_detect_mealy;

    logic       clk_125M = 1'b0;
    logic       clear_n;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       bit_valid;
    logic       bit_in;

    logic       out;
    logic [3:0] present_state;
    logic [7:0] match_cnt;
    logic       cfg_err;
    logic       out2;
    logic [3:0] present_state2;
    logic [1:0] match_cnt2;
    logic       cfg_err2;

    typedef struct {
        int   id;
        logic exp_out;
        int   exp_state;
        int   exp_cnt;
        logic exp_err;
        logic chk2;
        int   exp_cnt2;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  next_id  = 1;

    seq_detect_mealy dut (
        .clk_125M      (clk_125M),
        .clear_n       (clear_n),
        .cfg_load      (cfg_load),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_overlap   (cfg_overlap),
        .bit_valid     (bit_valid),
        .bit_in        (bit_in),
        .out           (out),
        .present_state (present_state),
        .match_cnt     (match_cnt),
        .cfg_err       (cfg_err)
    );

    seq_detect_mealy #(.CNT_W(2)) dut_sat (
        .clk_125M      (clk_125M),
        .clear_n       (clear_n),
        .cfg_load      (cfg_load),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_overlap   (cfg_overlap),
        .bit_valid     (bit_valid),
        .bit_in        (bit_in),
        .out           (out2),
        .present_state (present_state2),
        .match_cnt     (match_cnt2),
        .cfg_err       (cfg_err2)
    );

    always #4 clk_125M = ~clk_125M;

    task automatic check(input string name, input int id, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (txn %0d): got %0d, expected %0d", name, id, act, exp);
        end
    endtask

    // One cycle of stimulus; expectation queued before the strobe is presented.
    task automatic xact(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                        input logic ov, input logic v, input logic b, input logic eo,
                        input int es, input int ec, input logic ee,
                        input logic c2, input int ec2);
        sb_t e;
        e.id = next_id; e.exp_out = eo; e.exp_state = es; e.exp_cnt = ec;
        e.exp_err = ee; e.chk2 = c2; e.exp_cnt2 = ec2;
        next_id++;
        sb_q.push_back(e);
        cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
        bit_valid = v; bit_in = b;
        @(posedge clk_125M);
        #1;
        cfg_load  = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic send(input logic b, input logic eo, input int es, input int ec, input logic ee);
        xact(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, eo, es, ec, ee, 1'b0, 0);
    endtask

    task automatic send2(input logic b, input logic eo, input int es, input int ec, input int ec2);
        xact(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, eo, es, ec, 1'b0, 1'b1, ec2);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                        input int es, input int ec, input logic ee);
        xact(1'b1, pat, len, ov, 1'b0, 1'b0, 1'b0, es, ec, ee, 1'b0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_125M);
            #1;
        end
    endtask

    // Monitor: out sampled mid-cycle with the strobe, registered outputs after the edge.
    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk_125M);
            if (bit_valid || cfg_load) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", -1, 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("out", e.id, int'(out), int'(e.exp_out));
                    @(posedge clk_125M);
                    #1;
                    check("present_state", e.id, int'(present_state), e.exp_state);
                    check("match_cnt", e.id, int'(match_cnt), e.exp_cnt);
                    check("cfg_err", e.id, int'(cfg_err), int'(e.exp_err));
                    if (e.chk2) begin
                        check("match_cnt_sat", e.id, int'(match_cnt2), e.exp_cnt2);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        clear_n = 1'b0; cfg_load = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
        cfg_overlap = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        #10;
        check("rst_out", 0, int'(out), 0);
        check("rst_state", 0, int'(present_state), 0);
        check("rst_cnt", 0, int'(match_cnt), 0);
        check("rst_err", 0, int'(cfg_err), 0);
        @(negedge clk_125M);
        clear_n = 1'b1;
        @(posedge clk_125M);
        #1;

        // Reset defaults: 11011 overlapping, with an idle gap mid-pattern.
        send(1'b1, 1'b0, 1, 0, 1'b0);
        send(1'b1, 1'b0, 2, 0, 1'b0);
        send(1'b0, 1'b0, 3, 0, 1'b0);
        send(1'b1, 1'b0, 4, 0, 1'b0);
        idle(3);
        send(1'b1, 1'b1, 2, 1, 1'b0);
        send(1'b0, 1'b0, 3, 1, 1'b0);
        send(1'b1, 1'b0, 4, 1, 1'b0);
        send(1'b1, 1'b1, 2, 2, 1'b0);

        // 11011 non-overlapping.
        load(8'b0001_1011, 4'd5, 1'b0, 0, 0, 1'b0);
        send(1'b1, 1'b0, 1, 0, 1'b0);
        send(1'b1, 1'b0, 2, 0, 1'b0);
        send(1'b0, 1'b0, 3, 0, 1'b0);
        send(1'b1, 1'b0, 4, 0, 1'b0);
        send(1'b1, 1'b1, 0, 1, 1'b0);
        send(1'b0, 1'b0, 0, 1, 1'b0);
        send(1'b1, 1'b0, 1, 1, 1'b0);
        send(1'b1, 1'b0, 2, 1, 1'b0);

        // 1101 overlapping; junk above len must be ignored.
        load(8'b1010_1101, 4'd4, 1'b1, 0, 0, 1'b0);
        send(1'b1, 1'b0, 1, 0, 1'b0);
        send(1'b1, 1'b0, 2, 0, 1'b0);
        send(1'b1, 1'b0, 2, 0, 1'b0);
        send(1'b0, 1'b0, 3, 0, 1'b0);
        send(1'b1, 1'b1, 1, 1, 1'b0);

        // Illegal loads keep config, state and count; only cfg_err changes.
        load(8'b0001_1011, 4'd5, 1'b1, 0, 0, 1'b0);
        send(1'b1, 1'b0, 1, 0, 1'b0);
        send(1'b1, 1'b0, 2, 0, 1'b0);
        load(8'hFF, 4'd0, 1'b0, 2, 0, 1'b1);
        send(1'b0, 1'b0, 3, 0, 1'b1);
        send(1'b1, 1'b0, 4, 0, 1'b1);
        send(1'b1, 1'b1, 2, 1, 1'b1);
        load(8'h00, 4'd9, 1'b0, 2, 1, 1'b1);
        send(1'b0, 1'b0, 3, 1, 1'b1);
        load(8'b0000_1101, 4'd4, 1'b1, 0, 0, 1'b0);

        // Length boundaries: len 1 and len 8.
        load(8'b0000_0001, 4'd1, 1'b1, 0, 0, 1'b0);
        send(1'b1, 1'b1, 0, 1, 1'b0);
        send(1'b0, 1'b0, 0, 1, 1'b0);
        send(1'b1, 1'b1, 0, 2, 1'b0);
        load(8'b1000_0001, 4'd8, 1'b0, 0, 0, 1'b0);
        send(1'b1, 1'b0, 1, 0, 1'b0);
        for (int i = 2; i <= 7; i++) begin
            send(1'b0, 1'b0, i, 0, 1'b0);
        end
        send(1'b1, 1'b1, 0, 1, 1'b0);

        // Load coincident with a bit that would otherwise complete 1101.
        load(8'b0000_1101, 4'd4, 1'b1, 0, 0, 1'b0);
        send(1'b1, 1'b0, 1, 0, 1'b0);
        send(1'b1, 1'b0, 2, 0, 1'b0);
        send(1'b0, 1'b0, 3, 0, 1'b0);
        xact(1'b1, 8'b0000_1101, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        send(1'b1, 1'b0, 1, 0, 1'b0);
        send(1'b1, 1'b0, 2, 0, 1'b0);
        send(1'b0, 1'b0, 3, 0, 1'b0);
        send(1'b1, 1'b1, 1, 1, 1'b0);
        send(1'b1, 1'b0, 2, 1, 1'b0);
        send(1'b0, 1'b0, 3, 1, 1'b0);
        load(8'h00, 4'd0, 1'b0, 3, 1, 1'b1);

        // Asynchronous clear mid-pattern.
        #1;
        clear_n = 1'b0;
        #1;
        check("clr_out", 0, int'(out), 0);
        check("clr_state", 0, int'(present_state), 0);
        check("clr_cnt", 0, int'(match_cnt), 0);
        check("clr_err", 0, int'(cfg_err), 0);
        #1;
        clear_n = 1'b1;
        @(posedge clk_125M);
        #1;

        // Defaults restored; 2-bit counter saturates at 3 over five matches.
        send2(1'b1, 1'b0, 1, 0, 0);
        send2(1'b1, 1'b0, 2, 0, 0);
        send2(1'b0, 1'b0, 3, 0, 0);
        send2(1'b1, 1'b0, 4, 0, 0);
        for (int m = 1; m <= 5; m++) begin
            if (m > 1) begin
                send2(1'b0, 1'b0, 3, m - 1, (m - 1 > 3) ? 3 : m - 1);
                send2(1'b1, 1'b0, 4, m - 1, (m - 1 > 3) ? 3 : m - 1);
            end
            send2(1'b1, 1'b1, 2, m, (m > 3) ? 3 : m);
        end
        send2(1'b0, 1'b0, 3, 5, 3);

        idle(3);
        check("sb_drain", 0, sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_mealy.md
# seq_detect_mealy

Parametrised, runtime-programmable Mealy sequence detector; successor to the fixed 11011 detector. Consumes one serial bit per `bit_valid` strobe from the button/pulse stage (200 Hz domain pulses retimed to the system clock). Flags pattern completion combinationally, counts matches, and exposes match progress for LED display. Pattern, length and overlap mode are loadable at runtime; reset defaults reproduce the legacy 11011 overlapping detector.

## Interface
- `PAT_W`, 8: maximum pattern length in bits.
- `LEN_W`, $clog2(PAT_W+1): width of length and state fields.
- `CNT_W`, 8: match counter width.
- `RST_PATTERN`, 8'b0001_1011: pattern after reset, right-aligned.
- `RST_LEN`, 5: pattern length after reset.
- `RST_OVERLAP`, 1: overlap mode after reset.

- `clk_125M`  in  1  system clock; single clock domain.
- `clear_n`  in  1  asynchronous, active-low reset.
- `cfg_load`  in  1  one-cycle strobe; latch `cfg_*` and restart detection.
- `cfg_pattern`  in  PAT_W  pattern, right-aligned; bit `cfg_len-1` is received first.
- `cfg_len`  in  LEN_W  pattern length; legal range 1..PAT_W.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = restart after each match.
- `bit_valid`  in  1  one-cycle strobe; `bit_in` is valid this cycle.
- `bit_in`  in  1  serial data bit.
- `out`  out  1  Mealy match flag; combinational.
- `present_state`  out  LEN_W  number of pattern bits currently matched (0..len-1).
- `match_cnt`  out  CNT_W  saturating count of matches.
- `cfg_err`  out  1  sticky; the last `cfg_load` was illegal.

## Operation
- State s = length of the longest pattern prefix equal to the suffix of bits received. s never rests at len.
- History register `hist[PAT_W-1:0]`, with `hist[0]` the most recent bit. It shifts in `bit_in` on each accepted `bit_valid`.
- Next state on bit b: the largest k ≤ min(s+1, len) such that the first k pattern bits equal the last k bits, including b. The bound k ≤ s+1 guarantees no stale history is used.
- Match when k == len: `out` = 1.
  - Overlap mode: state becomes the largest k' < len satisfying the same prefix/suffix test (failure state).
  - Non-overlap mode: state becomes 0.
- `out` = `bit_valid` & match & ~`cfg_load`. It is 0 at all other times.
- `match_cnt` increments on each match and saturates at 2^CNT_W−1; there is no wrap.
- `cfg_load` with 1 ≤ `cfg_len` ≤ PAT_W:
  - latch pattern, length and mode; bits above len are ignored;
  - state ← 0, `hist` ← 0, `match_cnt` ← 0, `cfg_err` ← 0.
- `cfg_load` with an illegal length (0 or > PAT_W): configuration unchanged, `cfg_err` ← 1, state, count and history unchanged.
- `cfg_load` and `bit_valid` in the same cycle: the load wins and the bit is discarded.
- `bit_valid` low: all state is held.

## Timing
- `out` is valid in the same cycle as `bit_valid` (zero latency, Mealy).
- `present_state`, `match_cnt` and `cfg_err` update on the `clk_125M` rising edge after the triggering strobe.
- Back-to-back `bit_valid` on consecutive cycles is supported, one bit per cycle.
- `clear_n` low, asynchronously and independent of the clock: `present_state` = 0, `match_cnt` = 0, `cfg_err` = 0, `hist` = 0, config = RST_*, `out` = 0.
- Release of `clear_n` is synchronised externally.
- Reset mid-pattern discards all progress.

## Structure
- Package `seq_detect_pkg`: default values for `PAT_W`, `CNT_W`, `RST_PATTERN`, `RST_LEN`, `RST_OVERLAP`, and a `prefix_match(pattern, len, hist, k)` function.
- Sub-module `seq_next_state`: purely combinational.
  - Inputs: pattern, len, s, hist, b.
  - Outputs: next k, match flag, failure state.
  - Implemented as unrolled loops over k.
- Top module holds the registers, the counter and the config and error logic.

## Test plan
- Reset defaults (11011, overlap), stream 1,1,0,1,1,0,1,1 → `out` pulses on bits 5 and 8; `present_state` = 2 after bit 5; `match_cnt` = 2.
- Load 11011, len 5, overlap 0; same stream → `out` only on bit 5; `present_state` = 2 after bit 8; `match_cnt` = 1.
- Load 1101, len 4, overlap 1; stream 1,1,1,0,1 → `present_state` = 1,2,2,3, then `out` = 1 on bit 5 and state becomes 1.
- Illegal load (`cfg_len` = 0) → `cfg_err` = 1; 11011 still detected. A subsequent legal load clears `cfg_err`.
- `CNT_W` = 2, five matches → `match_cnt` = 3 and holds.
- Stream 1,1,0 then `clear_n` pulse → `present_state` = 0 and `match_cnt` = 0 immediately.
- `cfg_load` coincident with `bit_valid` → bit dropped, `out` = 0, state = 0.
